// File: rtl/arq_pkg.sv
// Shared types, default widths and parity helper for the ARQ receive checker.
package arq_pkg;

  localparam int unsigned DATA_W_DEF    = 4;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam int unsigned MAX_RETRY_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_FAIL  = 2'd2
  } state_e;

  // Caller zero-extends the payload; padding zeros do not change parity.
  function automatic logic even_par_ok(input logic [31:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/arq_rx_if.sv
// Link-side and consumer-side signals of the ARQ receive checker.
interface arq_rx_if
  import arq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF
);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_par;
  logic                  in_seq;
  logic                  out_rd_en;
  logic                  ack_out;
  logic                  nack_out;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  buf_full;
  logic                  busy;
  logic [RW-1:0]         retry_cnt;
  logic [7:0]            dup_cnt;
  logic                  link_fail;

  modport master (
    output in_valid, in_data, in_par, in_seq, out_rd_en,
    input  ack_out, nack_out, out_data, out_valid, buf_full,
           busy, retry_cnt, dup_cnt, link_fail
  );

  modport slave (
    input  in_valid, in_data, in_par, in_seq, out_rd_en,
    output ack_out, nack_out, out_data, out_valid, buf_full,
           busy, retry_cnt, dup_cnt, link_fail
  );

endinterface

// File: rtl/arq_rx_buf.sv
// First-word-fall-through receive FIFO with wrap-bit pointers.
module arq_rx_buf #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/arq_rx_checker.sv
// ARQ receive stage: parity/sequence check, ACK/NACK response, retry tracking, FWFT buffer.
module arq_rx_checker
  import arq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF
) (
  input logic   clk,
  input logic   rst_n,
  arq_rx_if.slave bus
);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_q, par_d;
  logic                  seq_q, seq_d;
  logic                  exp_seq_q, exp_seq_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [7:0]            dup_q, dup_d;
  logic                  ack_q, ack_d;
  logic                  nack_q, nack_d;
  logic                  fail_q, fail_d;
  logic                  wr_en;
  logic                  buf_empty;
  logic                  buf_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      seq_q     <= 1'b0;
      exp_seq_q <= 1'b0;
      retry_q   <= '0;
      dup_q     <= '0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      seq_q     <= seq_d;
      exp_seq_q <= exp_seq_d;
      retry_q   <= retry_d;
      dup_q     <= dup_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state and response decision; CHECK priority is parity, duplicate, full, accept.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    seq_d     = seq_q;
    exp_seq_d = exp_seq_q;
    retry_d   = retry_q;
    dup_d     = dup_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    fail_d    = fail_q;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          par_d   = bus.in_par;
          seq_d   = bus.in_seq;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!even_par_ok(32'(data_q), par_q)) begin
          retry_d = retry_q + RW'(1);
          if (retry_d == RW'(MAX_RETRY)) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            nack_d = 1'b1;
          end
        end else if (seq_q != exp_seq_q) begin
          ack_d = 1'b1;
          if (dup_q != 8'hFF) dup_d = dup_q + 8'd1;
        end else if (buf_full) begin
          nack_d = 1'b1;
        end else begin
          wr_en     = 1'b1;
          exp_seq_d = ~exp_seq_q;
          retry_d   = '0;
          ack_d     = 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  arq_rx_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_data(data_q),
    .rd_en  (bus.out_rd_en),
    .rd_data(bus.out_data),
    .empty  (buf_empty),
    .full   (buf_full)
  );

  assign bus.ack_out   = ack_q;
  assign bus.nack_out  = nack_q;
  assign bus.out_valid = !buf_empty;
  assign bus.buf_full  = buf_full;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.retry_cnt = retry_q;
  assign bus.dup_cnt   = dup_q;
  assign bus.link_fail = fail_q;

endmodule

// File: tb/tb_arq_rx_checker.sv
// Directed self-checking bench for arq_rx_checker.
module tb_arq_rx_checker;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  arq_rx_if #(.DATA_WIDTH(4), .MAX_RETRY(3)) bus ();

  arq_rx_checker #(.DATA_WIDTH(4), .DEPTH(4), .MAX_RETRY(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; pop_chk raises out_rd_en in the cycle the word is being checked.
  task automatic send(input string tag, input logic [3:0] d, input logic p, input logic s,
                      input logic eack, input logic enack, input logic pop_chk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_par   = p;
    bus.in_seq   = s;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_rd_en = pop_chk;
    @(negedge clk);
    bus.out_rd_en = 1'b0;
    chk({tag, ".ack"}, 32'(bus.ack_out), 32'(eack));
    chk({tag, ".nack"}, 32'(bus.nack_out), 32'(enack));
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] d);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".data"}, 32'(bus.out_data), 32'(d));
    bus.out_rd_en = 1'b1;
    @(negedge clk);
    bus.out_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] fill_data [4];

  initial begin
    n_total       = 0;
    n_bad         = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = 1'b0;
    bus.in_seq    = 1'b0;
    bus.out_rd_en = 1'b0;
    fill_data     = '{4'h1, 4'h2, 4'h5, 4'h6};

    do_reset();
    @(negedge clk);
    chk("rst.ack", 32'(bus.ack_out), 32'd0);
    chk("rst.nack", 32'(bus.nack_out), 32'd0);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.data", 32'(bus.out_data), 32'd0);
    chk("rst.full", 32'(bus.buf_full), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.retry", 32'(bus.retry_cnt), 32'd0);
    chk("rst.dup", 32'(bus.dup_cnt), 32'd0);
    chk("rst.fail", 32'(bus.link_fail), 32'd0);

    // Basic accept, with busy observed during CHECK
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 4'hA; bus.in_par = 1'b0; bus.in_seq = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t1.busy", 32'(bus.busy), 32'd1);
    chk("t1.ack_early", 32'(bus.ack_out), 32'd0);
    @(negedge clk);
    chk("t1.ack", 32'(bus.ack_out), 32'd1);
    chk("t1.nack", 32'(bus.nack_out), 32'd0);
    chk("t1.valid", 32'(bus.out_valid), 32'd1);
    chk("t1.data", 32'(bus.out_data), 32'hA);
    chk("t1.retry", 32'(bus.retry_cnt), 32'd0);
    @(negedge clk);
    chk("t1.pulse_end", 32'(bus.ack_out), 32'd0);

    // Duplicate re-acked but dropped
    send("t2", 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2.dup", 32'(bus.dup_cnt), 32'd1);
    pop_expect("t2.pop", 4'hA);
    @(negedge clk);
    chk("t2.empty", 32'(bus.out_valid), 32'd0);

    // Parity retries then recovery (exp_seq now 1)
    send("t3a", 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3a.retry", 32'(bus.retry_cnt), 32'd1);
    send("t3b", 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3b.retry", 32'(bus.retry_cnt), 32'd2);
    send("t3c", 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3c.retry", 32'(bus.retry_cnt), 32'd0);
    pop_expect("t3.pop", 4'h3);

    // Fill buffer, then full backpressure (exp_seq now 0)
    for (int i = 0; i < 4; i++)
      send("t5.fill", fill_data[i], ^fill_data[i], 1'(i), 1'b1, 1'b0, 1'b0);
    chk("t5.full", 32'(bus.buf_full), 32'd1);
    send("t5.over", 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5.full_after_pop", 32'(bus.buf_full), 32'd0);
    chk("t5.head", 32'(bus.out_data), 32'h2);
    send("t5.resend", 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5.dup_same", 32'(bus.dup_cnt), 32'd1);
    chk("t5.full_again", 32'(bus.buf_full), 32'd1);
    pop_expect("t5.p0", 4'h2);
    pop_expect("t5.p1", 4'h5);
    pop_expect("t5.p2", 4'h6);
    pop_expect("t5.p3", 4'h8);
    @(negedge clk);
    chk("t5.empty", 32'(bus.out_valid), 32'd0);

    // Simultaneous pop and write at two entries, across pointer wrap (exp_seq now 1)
    send("t6a", 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send("t6b", 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send("t6c", 4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    pop_expect("t6.p0", 4'hC);
    pop_expect("t6.p1", 4'hE);
    @(negedge clk);
    chk("t6.empty", 32'(bus.out_valid), 32'd0);

    // Retry exhaustion into sticky failure (exp_seq now 0)
    send("t4.keep", 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send("t4a", 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send("t4b", 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send("t4c", 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4.fail", 32'(bus.link_fail), 32'd1);
    chk("t4.retry", 32'(bus.retry_cnt), 32'd3);
    send("t4.ignored", 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4.fail_sticky", 32'(bus.link_fail), 32'd1);
    chk("t4.busy", 32'(bus.busy), 32'd1);
    pop_expect("t4.pop", 4'h5);
    @(negedge clk);
    chk("t4.empty", 32'(bus.out_valid), 32'd0);

    do_reset();
    @(negedge clk);
    chk("rst2.fail", 32'(bus.link_fail), 32'd0);
    chk("rst2.busy", 32'(bus.busy), 32'd0);
    chk("rst2.retry", 32'(bus.retry_cnt), 32'd0);
    send("rst2.accept", 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
